// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared widths, state encoding and default stage timeout
// Purpose: common definitions for the per-frame draw sequencer and its pixel mux.
// Ports: none (package).
package draw_pkg;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 6;

  localparam logic [15:0] DEF_TIMEOUT = 16'd50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP,
    ST_MAP_CLR,
    ST_SPR,
    ST_SPR_CLR,
    ST_DONE
  } draw_state_e;

endpackage

// File: rtl/frame_draw_ctrl_if.sv
// rtl/frame_draw_ctrl_if.sv - pixel write stream bundle (x, y, colour, write strobe)
// Purpose: one drawer-to-VGA pixel port.
// Ports: x / y / colour pixel coordinate and colour, write strobe.
//   master: drives the pixel (drawer or mux output); slave: consumes it.
interface frame_draw_ctrl_if;
  import draw_pkg::*;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [C_W-1:0] colour;
  logic           write;

  modport master (output x, y, colour, write);
  modport slave  (input  x, y, colour, write);

endinterface

// File: rtl/draw_mux.sv
// rtl/draw_mux.sv - combinational two-source pixel select with write gating
// Purpose: forwards the selected drawer's pixel to the VGA port; idle output is all zero.
// Ports:
//   sel_a / sel_b : source select (sel_a wins if both are set)
//   src_a / src_b : drawer pixel streams (slave)
//   dst           : pixel stream towards the VGA adapter (master)
module draw_mux (
  input  logic              sel_a,
  input  logic              sel_b,
  frame_draw_ctrl_if.slave  src_a,
  frame_draw_ctrl_if.slave  src_b,
  frame_draw_ctrl_if.master dst
);

  always_comb begin
    dst.x      = '0;
    dst.y      = '0;
    dst.colour = '0;
    dst.write  = 1'b0;
    if (sel_a) begin
      dst.x      = src_a.x;
      dst.y      = src_a.y;
      dst.colour = src_a.colour;
      dst.write  = src_a.write;
    end else if (sel_b) begin
      dst.x      = src_b.x;
      dst.y      = src_b.y;
      dst.colour = src_b.colour;
      dst.write  = src_b.write;
    end
  end

endmodule

// File: rtl/frame_draw_ctrl.sv
// rtl/frame_draw_ctrl.sv - per-frame map/sprite draw sequencer with VGA pixel mux
// Purpose: on each frame tick, runs the map drawer (only when a redraw is pending),
//   then the sprite drawer, and routes the active drawer's pixels to the VGA port.
// Ports:
//   clock, resetn              : clock, asynchronous active-low reset
//   frame_tick, map_redraw     : start-of-frame pulse, map redraw request pulse
//   map_enable/map_done/map_px : map drawer enable, done level, pixel stream
//   spr_enable/spr_done/spr_px : sprite drawer enable, done level, pixel stream
//   vga_px                     : selected pixel stream to the VGA adapter
//   busy, frame_done           : not idle, one-cycle end-of-frame pulse
//   overrun, timeout_err       : sticky tick-while-busy and stage-timeout flags
module frame_draw_ctrl
  import draw_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              frame_tick,
  input  logic              map_redraw,
  output logic              map_enable,
  frame_draw_ctrl_if.slave  map_px,
  input  logic              map_done,
  output logic              spr_enable,
  frame_draw_ctrl_if.slave  spr_px,
  input  logic              spr_done,
  frame_draw_ctrl_if.master vga_px,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic              timeout_err
);

  draw_state_e state_q, state_d;
  logic [15:0] timer_q, timer_d, timer_inc;
  logic        redraw_pend_q, redraw_pend_d;
  logic        overrun_q, overrun_d;
  logic        timeout_err_q, timeout_err_d;
  logic        pend_clr, stage_to;
  logic        sel_map, sel_spr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      redraw_pend_q <= 1'b1;  // first frame after reset always draws the map
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      redraw_pend_q <= redraw_pend_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Timer is zero outside the drawing states, so it is zero on every stage entry.
  // Comparing the incremented value keeps an enable high for at most TIMEOUT cycles.
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    timer_inc  = timer_q + 16'd1;
    map_enable = 1'b0;
    spr_enable = 1'b0;
    frame_done = 1'b0;
    pend_clr   = 1'b0;
    stage_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) state_d = redraw_pend_q ? ST_MAP : ST_SPR;
      end
      ST_MAP: begin
        map_enable = 1'b1;
        timer_d    = timer_inc;
        if (map_done) begin
          state_d  = ST_MAP_CLR;
          pend_clr = 1'b1;
        end else if (timer_inc == TIMEOUT) begin
          state_d  = ST_MAP_CLR;
          stage_to = 1'b1;
        end
      end
      ST_MAP_CLR: begin
        // hold off until the drawer has dropped done, i.e. has rearmed
        if (!map_done) state_d = ST_SPR;
      end
      ST_SPR: begin
        spr_enable = 1'b1;
        timer_d    = timer_inc;
        if (spr_done) begin
          state_d = ST_SPR_CLR;
        end else if (timer_inc == TIMEOUT) begin
          state_d  = ST_SPR_CLR;
          stage_to = 1'b1;
        end
      end
      ST_SPR_CLR: begin
        if (!spr_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new request in the same cycle as a successful map exit wins over the clear.
  assign redraw_pend_d = map_redraw | (redraw_pend_q & ~pend_clr);
  assign overrun_d     = overrun_q | (frame_tick & busy);
  assign timeout_err_d = timeout_err_q | stage_to;

  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

  assign sel_map = (state_q == ST_MAP);
  assign sel_spr = (state_q == ST_SPR);

  draw_mux u_mux (
    .sel_a (sel_map),
    .sel_b (sel_spr),
    .src_a (map_px),
    .src_b (spr_px),
    .dst   (vga_px)
  );

endmodule
